// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  // Byte offset bits inside a data word.
  localparam int WORD_OFFSET_BITS = 2;

  // Field widths of the queued request record.
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  // Service engine states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } eng_state_e;

  // Request record as it sits in the queue and the active register.
  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } dmem_req_t;

  localparam int REQ_W = $bits(dmem_req_t);

  // High when the byte address is not word aligned or its word index
  // falls outside a 2**depth_log2 word array.
  function automatic logic addr_err(input logic [REQ_ADDR_W-1:0] addr,
                                    input int depth_log2);
    logic [REQ_ADDR_W-1:0] widx;
    widx = addr >> WORD_OFFSET_BITS;
    return (addr[WORD_OFFSET_BITS-1:0] != '0) || ((widx >> depth_log2) != '0);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage request/response bus between the pipeline and the responder.
interface dmem_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = REQ_ADDR_W,
  parameter int DATA_W = REQ_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  // Pipeline side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  // Memory side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_req_fifo.sv
// Small request queue: QDEPTH entries, wrapping pointers, occupancy count.
module dmem_req_fifo
  import dmem_pkg::*;
#(
  parameter int W      = REQ_W,
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [W-1:0]              din,
  input  logic                      pop,
  output logic [W-1:0]              dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(QDEPTH):0]   count
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == CW'(QDEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: queues MEM-stage word requests, waits LATENCY
// cycles per request, then commits the store or returns the load word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = REQ_ADDR_W,
  parameter int DATA_W     = REQ_DATA_W,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int QDEPTH     = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);
  localparam int         CW     = $clog2(QDEPTH) + 1;
  localparam int         NWORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic                  rdy_en_q;
  logic                  push, pop;
  logic                  q_full, q_empty;
  logic [CW-1:0]         q_count;
  dmem_req_t             q_din, q_dout, act_q;
  eng_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  enter_resp;
  logic                  act_err;
  logic [ADDR_W-1:0]     act_addr;
  logic [DEPTH_LOG2-1:0] act_idx;
  logic [DATA_W-1:0]     mem [NWORDS];
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;

  assign bus.req_ready = rdy_en_q && !q_full;
  assign push          = bus.req_valid && bus.req_ready;
  assign q_din         = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};

  dmem_req_fifo #(.W(REQ_W), .QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (q_din),
    .pop   (pop),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Hold req_ready low through reset and for the edge that releases it.
  always_ff @(posedge clk) begin
    rdy_en_q <= rst;
  end

  // Engine next state: pop in IDLE, count down in WAIT, one RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Engine state register; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Active request register, loaded on every pop.
  always_ff @(posedge clk) begin
    if (pop) act_q <= q_dout;
  end

  assign enter_resp = (state_q == WAIT) && (cnt_q == '0);
  assign act_addr   = act_q.addr;
  assign act_err    = addr_err(act_q.addr, DEPTH_LOG2);
  assign act_idx    = act_addr[DEPTH_LOG2+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];

  // Response data is captured on the edge into RESP so it is valid for the
  // whole RESP cycle, and cleared on the way out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= act_err;
      rdata_q <= (act_err || act_q.we) ? '0 : mem[act_idx];
    end else begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  // Stores commit on the same edge the response is launched, so a reset that
  // suppresses the response also suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && act_q.we && !act_err) mem[act_idx] <= act_q.wdata;
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (q_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 15) checked every
// cycle against a timing/memory model, plus hand-computed directed checks.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int NI = 3;
  localparam int QD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       r_valid, r_we;
  logic [NI-1:0][31:0] r_addr, r_wd;
  logic [NI-1:0]       d_valid, d_ready, d_err, d_busy;
  logic [NI-1:0][31:0] d_rdata;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 15;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    dmem_if bus ();
    dmem_responder #(.LATENCY(lat_of(g)), .QDEPTH(QD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.req_valid = r_valid[g];
    assign bus.req_we    = r_we[g];
    assign bus.req_addr  = r_addr[g];
    assign bus.req_wdata = r_wd[g];
    assign d_valid[g]    = bus.rsp_valid;
    assign d_ready[g]    = bus.req_ready;
    assign d_err[g]      = bus.rsp_err;
    assign d_busy[g]     = bus.busy;
    assign d_rdata[g]    = bus.rsp_rdata;
  end

  // Model: each accepted request gets its pop edge and response edge.
  typedef struct {
    int          p;
    int          r;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } ent_t;

  ent_t        mq [NI][$];
  logic [31:0] mmem [NI][1024];
  bit          mknown [NI][1024];
  int          last_r [NI];
  bit          en_m = 1'b0;
  bit          armed = 1'b0;
  int          cyc = 0;
  int          nchk = 0;
  int          nfail = 0;

  int          obs_c [NI][$];
  logic [31:0] obs_d [NI][$];
  logic        obs_e [NI][$];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Per-cycle compare against the model, then advance the model to next edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < NI; i++) begin
        bit          ev, eb, ee, known;
        int          inq, idx;
        logic [31:0] er;
        ev  = (mq[i].size() > 0) && (mq[i][0].r == cyc);
        inq = 0;
        eb  = 1'b0;
        for (int k = 0; k < mq[i].size(); k++) begin
          if (mq[i][k].p > cyc)  inq++;
          if (mq[i][k].r >= cyc) eb = 1'b1;
        end
        chk($sformatf("rsp_valid[%0d]", i), d_valid[i], ev);
        chk($sformatf("busy[%0d]", i), d_busy[i], eb);
        chk($sformatf("req_ready[%0d]", i), d_ready[i], en_m && (inq < QD));
        er    = '0;
        ee    = 1'b0;
        known = 1'b1;
        if (ev) begin
          ee  = (mq[i][0].addr[1:0] != 2'b00) || (mq[i][0].addr >= 32'h1000);
          idx = int'(mq[i][0].addr[11:2]);
          if (!ee && !mq[i][0].we) begin
            er    = mmem[i][idx];
            known = mknown[i][idx];
          end
          if (!ee && mq[i][0].we) begin
            mmem[i][idx]   = mq[i][0].wd;
            mknown[i][idx] = 1'b1;
          end
          void'(mq[i].pop_front());
        end
        if (known) chk($sformatf("rsp_rdata[%0d]", i), d_rdata[i], er);
        chk($sformatf("rsp_err[%0d]", i), d_err[i], ee);
        if (d_valid[i]) begin
          obs_c[i].push_back(cyc);
          obs_d[i].push_back(d_rdata[i]);
          obs_e[i].push_back(d_err[i]);
        end
        if (!rst) begin
          mq[i].delete();
          last_r[i] = -100;
        end else if (r_valid[i] && en_m && (inq < QD)) begin
          ent_t ne;
          int   e;
          e       = cyc + 1;
          ne.p    = (e + 1 > last_r[i] + 2) ? e + 1 : last_r[i] + 2;
          ne.r    = ne.p + lat_of(i);
          ne.we   = r_we[i];
          ne.addr = r_addr[i];
          ne.wd   = r_wd[i];
          last_r[i] = ne.r;
          mq[i].push_back(ne);
        end
      end
      en_m = rst;
    end
  end

  task automatic issue(input int i, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, output int e);
    int t;
    t = 0;
    r_valid[i] = 1'b1;
    r_we[i]    = we;
    r_addr[i]  = a;
    r_wd[i]    = wd;
    while (!d_ready[i] && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) chk("issue_timeout", 1, 0);
    @(posedge clk); #1;
    e = cyc;
    r_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int t;
    t = 0;
    while ((d_busy[i] || mq[i].size() != 0) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) chk("idle_timeout", 1, 0);
  endtask

  task automatic clr_obs(input int i);
    obs_c[i].delete();
    obs_d[i].delete();
    obs_e[i].delete();
  endtask

  task automatic exp_obs(input int i, input string nm, input int c,
                         input logic [31:0] d, input logic er);
    if (obs_c[i].size() == 0) begin
      chk({nm, "_present"}, 0, 1);
    end else begin
      chk({nm, "_cycle"}, obs_c[i].pop_front(), c);
      chk({nm, "_rdata"}, obs_d[i].pop_front(), d);
      chk({nm, "_err"},   obs_e[i].pop_front(), er);
    end
  endtask

  task automatic rand_run(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      int          g, sel, e;
      logic [31:0] a;
      g = $urandom_range(0, 3);
      repeat (g) begin @(posedge clk); #1; end
      sel = $urandom_range(0, 9);
      a   = 32'($urandom_range(0, 15)) << 2;
      if (sel == 8)      a = a | 32'($urandom_range(1, 3));
      else if (sel == 9) a = a + 32'h1000 * 32'($urandom_range(1, 4));
      issue(i, 1'($urandom_range(0, 1)), a, $urandom, e);
    end
  endtask

  initial begin
    int e1, e2, e3, e4;
    r_valid = '0; r_we = '0; r_addr = '0; r_wd = '0;
    for (int i = 0; i < NI; i++) begin
      last_r[i] = -100;
      for (int w = 0; w < 1024; w++) mknown[i][w] = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    armed = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("reset_rsp_valid", d_valid, 0);
    chk("reset_busy", d_busy, 0);
    chk("reset_ready", d_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", d_ready, 3'b111);

    // Store then load the same word.
    clr_obs(0);
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, e1);
    issue(0, 1'b0, 32'h10, 32'h0, e2);
    wait_idle(0);
    exp_obs(0, "st10", e1 + 3, 32'h0, 1'b0);
    exp_obs(0, "ld10", e1 + 7, 32'hDEADBEEF, 1'b0);

    // Queue full: fourth request is held off until the second one pops.
    clr_obs(0);
    issue(0, 1'b1, 32'h40, 32'h1, e1);
    issue(0, 1'b1, 32'h44, 32'h2, e2);
    issue(0, 1'b0, 32'h40, 32'h0, e3);
    chk("full_ready", d_ready[0], 0);
    issue(0, 1'b0, 32'h44, 32'h0, e4);
    chk("full_acc2", e2, e1 + 1);
    chk("full_acc3", e3, e1 + 2);
    chk("full_acc4", e4, e1 + 6);
    wait_idle(0);
    exp_obs(0, "full1", e1 + 3,  32'h0, 1'b0);
    exp_obs(0, "full2", e1 + 7,  32'h0, 1'b0);
    exp_obs(0, "full3", e1 + 11, 32'h1, 1'b0);
    exp_obs(0, "full4", e1 + 15, 32'h2, 1'b0);

    // Misaligned and out-of-range accesses.
    clr_obs(0);
    issue(0, 1'b1, 32'h0, 32'hA5A5A5A5, e1);
    issue(0, 1'b0, 32'h13, 32'h0, e2);
    issue(0, 1'b1, 32'h1000, 32'h12345678, e3);
    issue(0, 1'b0, 32'h0, 32'h0, e4);
    wait_idle(0);
    exp_obs(0, "st0",    e1 + 3,  32'h0, 1'b0);
    exp_obs(0, "ld13",   e1 + 7,  32'h0, 1'b1);
    exp_obs(0, "st1000", e1 + 11, 32'h0, 1'b1);
    exp_obs(0, "ld0",    e1 + 15, 32'hA5A5A5A5, 1'b0);

    // Reset while one request waits and another is queued.
    issue(0, 1'b1, 32'h20, 32'h55AA0001, e1);
    wait_idle(0);
    clr_obs(0);
    issue(0, 1'b0, 32'h24, 32'h0, e1);
    issue(0, 1'b0, 32'h20, 32'h0, e2);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    chk("midrst_no_rsp", obs_c[0].size(), 0);
    chk("midrst_busy", d_busy[0], 0);
    issue(0, 1'b0, 32'h20, 32'h0, e1);
    wait_idle(0);
    exp_obs(0, "ld20_after_rst", e1 + 3, 32'h55AA0001, 1'b0);

    // Latency sweep on the LATENCY=1 and LATENCY=15 instances.
    issue(1, 1'b1, 32'h8, 32'h11, e1);
    wait_idle(1);
    clr_obs(1);
    issue(1, 1'b0, 32'h8, 32'h0, e1);
    wait_idle(1);
    exp_obs(1, "lat1", e1 + 2, 32'h11, 1'b0);
    issue(2, 1'b1, 32'h8, 32'h22, e1);
    wait_idle(2);
    clr_obs(2);
    issue(2, 1'b0, 32'h8, 32'h0, e1);
    wait_idle(2);
    exp_obs(2, "lat15", e1 + 16, 32'h22, 1'b0);

    // Random traffic, model checked every cycle.
    fork
      rand_run(0, 150);
      rand_run(1, 80);
      rand_run(2, 12);
    join
    for (int i = 0; i < NI; i++) wait_idle(i);
    repeat (3) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", nchk);
    $fatal(1, "watchdog");
  end

endmodule
